spgemm_pp_stream_tx: RTL and testbench
======================================

// Module: spgemm_pp_stream_tx
// PURPOSE
//  Partial-product stream transmitter: drives the merge PE input (valid/ready, val/row/col/last).
//  Each job is one nonzero A(i,k); block reads B row k from a 1-cycle-latency CSR port,
//  multiplies by a_val and emits (a*b, i, col) in B's column order, so vector boundaries
//  (col decrease) appear between jobs. Sits between CSR fetch and matraptor_core.
// PARAMETERS
//  DATA_W    32  value width (a, b, product)
//  IDX_W     16  row/col index width
//  ADDR_W    16  B-memory address width
//  LEN_W     16  B-row length width
//  OUT_DEPTH 2   output FIFO entries (>=2)
// PORTS
//  clk           in  1        clock
//  rst           in  1        async reset, active-high
//  job_valid     in  1        job offered
//  job_ready     out 1        job accepted when valid&ready
//  job_a_val     in  DATA_W   A(i,k) value
//  job_a_row     in  IDX_W    row i
//  job_b_ptr     in  ADDR_W   start address of B row k
//  job_b_len     in  LEN_W    nonzeros in B row k
//  job_row_last  in  1        last job of row i
//  job_last      in  1        last job of matrix
//  b_rd_en       out 1        B read strobe
//  b_rd_addr     out ADDR_W   B read address
//  b_rd_val      in  DATA_W   B value, valid cycle after b_rd_en
//  b_rd_col      in  IDX_W    B column, valid cycle after b_rd_en
//  out_valid     out 1        product valid
//  out_ready     in  1        downstream ready
//  out_val       out DATA_W   product
//  out_row       out IDX_W    row i
//  out_col       out IDX_W    column
//  out_last      out 1        last product of row i
//  done          out 1        1-cycle pulse, matrix finished
//  col_order_err out 1        sticky: cols within a job not strictly ascending
// BEHAVIOUR
//  Reset (async, rst=1): all outputs 0 (job_ready, b_rd_en, out_valid, done, col_order_err),
//   FIFO emptied, in-flight read discarded, FSM->S_IDLE; applies mid-job, no partial flush.
//  FSM: S_IDLE: job_ready=1 (0 while rst). Accept: latch job; len==0 -> stay S_IDLE, no output,
//   row_last/last of that job dropped except job_last (-> S_DRAIN); len>0 -> S_ISSUE.
//   S_ISSUE: b_rd_en=1 when credit, addr=b_ptr+idx, idx++ per read; after read len-1 issued:
//   job_last ? S_DRAIN : S_IDLE (next job may be accepted next cycle; reads pipeline).
//   S_DRAIN: job_ready=0; when FIFO empty and no read in flight -> done=1 one cycle, -> S_IDLE.
//  Credit: issue only if fifo_count + inflight - pop < OUT_DEPTH (pop = out_valid&out_ready).
//   No product ever dropped or duplicated; order preserved.
//  Data: cycle after read, FIFO push {a_val*b_rd_val [DATA_W-1:0] (truncate, wrap), a_row,
//   b_rd_col, last = job_row_last & final read of job}.
//  Latency: job accept T -> first read T+1 -> first out_valid T+3; 1 product/cycle with out_ready=1.
//  Output: out_* = FIFO head; out_valid=!empty; payload stable while valid&!ready.
//  Simultaneous push/pop at full allowed (credit guarantees no overflow).
//  col_order_err: set cycle after a read whose col <= previous col of same job; cleared only
//   by rst; stream continues unchanged.
//  Address wrap: b_ptr+idx wraps modulo 2^ADDR_W.
// TESTING
//  1 job a=3,row=5,B cols{1,4,7} vals{2,5,10},row_last=1,ready=1 -> (6,5,1,0),(15,5,4,0),(30,5,7,1) cycles T+3..T+5.
//  Same job, out_ready=0 for 5 cycles after first output -> b_rd_en stalls at OUT_DEPTH credit; all 3 outputs exact, in order.
//  Job len=0 then job len=2 a=1 cols{0,2} -> no output for first; second yields (b0,row,0),(b2,row,2).
//  a=0x10000,b=0x10000 (DATA_W=32) -> out_val=0x0; a=0xFFFFFFFF,b=2 -> 0xFFFFFFFE.
//  B cols{3,3} in one job -> col_order_err=1 after second data, held until rst; job_last -> done pulse once after drain.
//  rst=1 mid-job with FIFO holding 1 entry -> out_valid=0 immediately; new job after release outputs normally.

Source files
------------

// File: rtl/spgemm_pp_stream_tx.sv
// rtl/spgemm_pp_stream_tx.sv - partial-product stream transmitter feeding the merge PE
// One job per nonzero A(i,k): reads B row k, scales by a_val, streams (a*b, i, col) in order.
module spgemm_pp_stream_tx #(
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 16,
    parameter int ADDR_W    = 16,
    parameter int LEN_W     = 16,
    parameter int OUT_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_a_val,
    input  logic [IDX_W-1:0]  job_a_row,
    input  logic [ADDR_W-1:0] job_b_ptr,
    input  logic [LEN_W-1:0]  job_b_len,
    input  logic              job_row_last,
    input  logic              job_last,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [DATA_W-1:0] b_rd_val,
    input  logic [IDX_W-1:0]  b_rd_col,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_val,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_col,
    output logic              out_last,
    output logic              done,
    output logic              col_order_err
);

    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
    state_t state, state_nx;

    logic [DATA_W-1:0] j_a_val;
    logic [IDX_W-1:0]  j_a_row;
    logic [ADDR_W-1:0] j_b_ptr;
    logic [LEN_W-1:0]  j_b_len;
    logic              j_row_last;
    logic              j_last;
    logic [LEN_W-1:0]  idx;

    // Metadata travelling alongside the single outstanding B read
    logic              rd_pend;
    logic [DATA_W-1:0] p_a_val;
    logic [IDX_W-1:0]  p_row;
    logic              p_last;
    logic              p_first;
    logic [IDX_W-1:0]  prev_col;

    logic [DATA_W-1:0] f_val  [OUT_DEPTH];
    logic [IDX_W-1:0]  f_row  [OUT_DEPTH];
    logic [IDX_W-1:0]  f_col  [OUT_DEPTH];
    logic              f_last [OUT_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              accept;
    logic              pop;
    logic              push;
    logic              credit;
    logic              last_rd;
    logic [CW:0]       occ;
    logic [DATA_W-1:0] prod;

    assign pop       = out_valid & out_ready;
    assign push      = rd_pend;
    assign occ       = {1'b0, count} + {{CW{1'b0}}, rd_pend} - {{CW{1'b0}}, pop};
    assign credit    = occ < (CW+1)'(OUT_DEPTH);
    assign last_rd   = (idx == j_b_len - LEN_W'(1));
    assign b_rd_addr = j_b_ptr + ADDR_W'(idx);
    assign prod      = p_a_val * b_rd_val;

    assign out_valid = (count != '0);
    assign out_val   = f_val[rd_ptr];
    assign out_row   = f_row[rd_ptr];
    assign out_col   = f_col[rd_ptr];
    assign out_last  = f_last[rd_ptr];

    always_comb begin
        state_nx  = state;
        job_ready = 1'b0;
        b_rd_en   = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                job_ready = !rst;
                if (job_valid && !rst) begin
                    accept = 1'b1;
                    if (job_b_len == '0)
                        state_nx = job_last ? S_DRAIN : S_IDLE;
                    else
                        state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                b_rd_en = credit;
                if (credit && last_rd)
                    state_nx = j_last ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (count == '0 && !rd_pend) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            j_a_val       <= '0;
            j_a_row       <= '0;
            j_b_ptr       <= '0;
            j_b_len       <= '0;
            j_row_last    <= 1'b0;
            j_last        <= 1'b0;
            idx           <= '0;
            rd_pend       <= 1'b0;
            p_a_val       <= '0;
            p_row         <= '0;
            p_last        <= 1'b0;
            p_first       <= 1'b0;
            prev_col      <= '0;
            col_order_err <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                f_val[i]  <= '0;
                f_row[i]  <= '0;
                f_col[i]  <= '0;
                f_last[i] <= 1'b0;
            end
        end else begin
            state   <= state_nx;
            rd_pend <= b_rd_en;
            if (accept) begin
                j_a_val    <= job_a_val;
                j_a_row    <= job_a_row;
                j_b_ptr    <= job_b_ptr;
                j_b_len    <= job_b_len;
                j_row_last <= job_row_last;
                j_last     <= job_last;
                idx        <= '0;
            end
            if (b_rd_en) begin
                idx     <= idx + LEN_W'(1);
                p_a_val <= j_a_val;
                p_row   <= j_a_row;
                p_last  <= j_row_last & last_rd;
                p_first <= (idx == '0);
            end
            if (push) begin
                f_val[wr_ptr]  <= prod;
                f_row[wr_ptr]  <= p_row;
                f_col[wr_ptr]  <= b_rd_col;
                f_last[wr_ptr] <= p_last;
                wr_ptr   <= (wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                prev_col <= b_rd_col;
                if (!p_first && b_rd_col <= prev_col)
                    col_order_err <= 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_spgemm_pp_stream_tx.sv
// tb/tb_spgemm_pp_stream_tx.sv - self-checking bench for spgemm_pp_stream_tx
// Expected stream built per job from B memory contents; outputs compared every pop.
module tb_spgemm_pp_stream_tx;

    localparam int DW = 32;
    localparam int IW = 16;
    localparam int AW = 16;
    localparam int LW = 16;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          job_valid;
    logic          job_ready;
    logic [DW-1:0] job_a_val;
    logic [IW-1:0] job_a_row;
    logic [AW-1:0] job_b_ptr;
    logic [LW-1:0] job_b_len;
    logic          job_row_last;
    logic          job_last;
    logic          b_rd_en;
    logic [AW-1:0] b_rd_addr;
    logic [DW-1:0] b_rd_val = '0;
    logic [IW-1:0] b_rd_col = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_val;
    logic [IW-1:0] out_row;
    logic [IW-1:0] out_col;
    logic          out_last;
    logic          done;
    logic          col_order_err;

    spgemm_pp_stream_tx #(
        .DATA_W(DW), .IDX_W(IW), .ADDR_W(AW), .LEN_W(LW), .OUT_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_a_val(job_a_val), .job_a_row(job_a_row),
        .job_b_ptr(job_b_ptr), .job_b_len(job_b_len),
        .job_row_last(job_row_last), .job_last(job_last),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
        .b_rd_val(b_rd_val), .b_rd_col(b_rd_col),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_val(out_val), .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .done(done), .col_order_err(col_order_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] val;
        logic [IW-1:0] row;
        logic [IW-1:0] col;
        logic          last;
    } pp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   rd_cnt = 0;
    int   pop_cnt = 0;
    int   done_cnt = 0;
    pp_t  exp_q[$];
    pp_t  log_q[$];
    int   log_cyc[$];
    pp_t  cur, held, head;
    logic held_v = 1'b0;

    logic [DW-1:0] mem_val [256];
    logic [IW-1:0] mem_col [256];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // B memory: registered read, one cycle latency
    always @(posedge clk) begin
        if (b_rd_en) begin
            b_rd_val <= mem_val[b_rd_addr[7:0]];
            b_rd_col <= mem_col[b_rd_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rd_cnt  = 0;
            pop_cnt = 0;
        end else begin
            if (b_rd_en) rd_cnt++;
            if (out_valid && out_ready) pop_cnt++;
        end
    end

    always @(negedge clk) begin
        #1;
        cur = {out_val, out_row, out_col, out_last};
        if (done) done_cnt++;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            chk("credit_bound", ((rd_cnt - pop_cnt) <= D), 1);
            if (held_v) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_payload_held", cur, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", cur, 0);
                end else begin
                    head = exp_q.pop_front();
                    chk("out_payload", cur, head);
                end
                log_q.push_back(cur);
                log_cyc.push_back(cyc);
            end
            held_v = out_valid && !out_ready;
            held   = cur;
        end
    end

    task automatic send_job(input logic [DW-1:0] a, input logic [IW-1:0] row,
                            input logic [AW-1:0] ptr, input logic [LW-1:0] len,
                            input logic rl, input logic last);
        int n;
        logic [AW-1:0] addr;
        logic [DW-1:0] p;
        @(negedge clk);
        job_a_val = a; job_a_row = row; job_b_ptr = ptr; job_b_len = len;
        job_row_last = rl; job_last = last; job_valid = 1'b1;
        n = 0;
        while (!job_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!job_ready) begin
            chk("job_accept_timeout", 0, 1);
            job_valid = 1'b0;
            return;
        end
        for (int j = 0; j < int'(len); j++) begin
            addr = ptr + AW'(j);
            p    = a * mem_val[addr[7:0]];
            exp_q.push_back({p, row, mem_col[addr[7:0]], rl && (j == int'(len) - 1)});
        end
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        job_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic check_t1(input string tag, input int base, input logic timing);
        chk({tag, "_count"}, log_q.size() - base, 3);
        chk({tag, "_p0"}, log_q[base],     {32'd6,  16'd5, 16'd1, 1'b0});
        chk({tag, "_p1"}, log_q[base + 1], {32'd15, 16'd5, 16'd4, 1'b0});
        chk({tag, "_p2"}, log_q[base + 2], {32'd30, 16'd5, 16'd7, 1'b1});
        if (timing) begin
            chk({tag, "_t3"}, log_cyc[base],     acc_cyc + 2);
            chk({tag, "_t4"}, log_cyc[base + 1], acc_cyc + 3);
            chk({tag, "_t5"}, log_cyc[base + 2], acc_cyc + 4);
        end
    endtask

    int base, d0, r0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_val[i] = 32'hdead0000 | i;
            mem_col[i] = IW'(i);
        end
        mem_val[8'h10] = 2;  mem_col[8'h10] = 1;
        mem_val[8'h11] = 5;  mem_col[8'h11] = 4;
        mem_val[8'h12] = 10; mem_col[8'h12] = 7;
        mem_val[8'h20] = 11; mem_col[8'h20] = 0;
        mem_val[8'h21] = 22; mem_col[8'h21] = 2;
        mem_val[8'h30] = 32'h10000; mem_col[8'h30] = 0;
        mem_val[8'h31] = 2;         mem_col[8'h31] = 1;
        mem_val[8'h40] = 1;  mem_col[8'h40] = 3;
        mem_val[8'h41] = 1;  mem_col[8'h41] = 3;
        mem_val[8'hFF] = 9;  mem_col[8'hFF] = 5;
        mem_val[8'h00] = 4;  mem_col[8'h00] = 6;
        for (int i = 0; i < 4; i++) begin
            mem_val[8'h50 + i] = i + 1;
            mem_col[8'h50 + i] = IW'(i);
        end

        rst = 1'b1; job_valid = 1'b0; out_ready = 1'b1;
        job_a_val = '0; job_a_row = '0; job_b_ptr = '0; job_b_len = '0;
        job_row_last = 1'b0; job_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_job_ready", job_ready, 0);
        chk("rst_outputs", {b_rd_en, out_valid, done, col_order_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_job_ready", job_ready, 1);

        // basic job with exact latency
        base = log_q.size();
        send_job(3, 5, 16'h10, 3, 1, 0);
        @(negedge clk);
        chk("first_read_en", b_rd_en, 1);
        chk("first_read_addr", b_rd_addr, 16'h10);
        wait_drain();
        check_t1("t1", base, 1'b1);

        // stall after first output
        base = log_q.size();
        send_job(3, 5, 16'h10, 3, 1, 0);
        wait_out_valid();
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
        wait_drain();
        check_t1("t2", base, 1'b0);

        // full stall: reads stop at the credit limit
        out_ready = 1'b0;
        r0 = rd_cnt;
        send_job(5, 7, 16'h50, 4, 1, 0);
        repeat (10) @(negedge clk);
        chk("stall_read_count", rd_cnt - r0, D);
        out_ready = 1'b1;
        wait_drain();

        // empty job then two-entry job
        base = log_q.size();
        d0 = done_cnt;
        send_job(9, 8, 16'h20, 0, 1, 0);
        send_job(1, 9, 16'h20, 2, 1, 0);
        wait_drain();
        chk("t3_count", log_q.size() - base, 2);
        chk("t3_p0", log_q[base],     {32'd11, 16'd9, 16'd0, 1'b0});
        chk("t3_p1", log_q[base + 1], {32'd22, 16'd9, 16'd2, 1'b1});
        chk("t3_no_done", done_cnt - d0, 0);

        // product truncation
        base = log_q.size();
        send_job(32'h10000, 1, 16'h30, 1, 1, 0);
        send_job(32'hFFFFFFFF, 1, 16'h31, 1, 1, 0);
        wait_drain();
        chk("trunc_zero", log_q[base].val, 32'h0);
        chk("trunc_wrap", log_q[base + 1].val, 32'hFFFFFFFE);

        // address wrap
        base = log_q.size();
        send_job(2, 3, 16'hFFFF, 2, 1, 0);
        wait_drain();
        chk("wrap_p0", log_q[base],     {32'd18, 16'd3, 16'd5, 1'b0});
        chk("wrap_p1", log_q[base + 1], {32'd8,  16'd3, 16'd6, 1'b1});

        // repeated column plus matrix-last drain
        chk("col_err_clear", col_order_err, 0);
        d0 = done_cnt;
        send_job(7, 2, 16'h40, 2, 1, 1);
        wait_drain();
        repeat (5) @(negedge clk);
        chk("col_err_set", col_order_err, 1);
        chk("done_once", done_cnt - d0, 1);
        d0 = done_cnt;
        send_job(0, 0, 16'h0, 0, 0, 1);
        repeat (5) @(negedge clk);
        chk("done_empty_last", done_cnt - d0, 1);
        chk("col_err_sticky", col_order_err, 1);

        // reset mid-job with one entry held
        out_ready = 1'b0;
        send_job(3, 5, 16'h10, 3, 1, 0);
        wait_out_valid();
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_job_ready", job_ready, 0);
        chk("midrst_col_err", col_order_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        base = log_q.size();
        send_job(3, 5, 16'h10, 3, 1, 0);
        wait_drain();
        check_t1("t8", base, 1'b1);
        repeat (3) @(negedge clk);
        chk("final_idle", {out_valid, b_rd_en}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
